// File: rtl/mtc_thread_scheduler.sv
// Round-robin dispatcher from sector-logic candidates onto the pT-calc thread pool.
// Tracks per-thread busy state, releases on done or watchdog expiry, keeps statistics.
module mtc_thread_scheduler #(
    parameter int c_NUM_THREADS = 3,
    parameter int SL_ID_WIDTH   = 4,
    parameter int TIMEOUT       = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     srst,
    input  logic                     sl_valid,
    input  logic [SL_ID_WIDTH-1:0]   sl_id,
    output logic                     sl_ready,
    input  logic [c_NUM_THREADS-1:0] thread_done,
    output logic                     dispatch_valid,
    output logic [c_NUM_THREADS-1:0] dispatch_thread,
    output logic [SL_ID_WIDTH-1:0]   dispatch_id,
    output logic [c_NUM_THREADS-1:0] thread_busy,
    output logic [c_NUM_THREADS-1:0] timeout_pulse,
    output logic [CNT_WIDTH-1:0]     dispatch_count,
    output logic [CNT_WIDTH-1:0]     timeout_count
);

    localparam int PTR_W = $clog2(c_NUM_THREADS);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(c_NUM_THREADS - 1);
    localparam logic [PTR_W:0]   PTR_NUM  = (PTR_W + 1)'(c_NUM_THREADS);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         sel_idx;
    logic [c_NUM_THREADS-1:0] sel_onehot;
    logic [c_NUM_THREADS-1:0] timeout_hit;
    logic [c_NUM_THREADS-1:0] release_mask;
    logic [WD_W-1:0]          watchdog [c_NUM_THREADS];
    logic                     accept;

    assign sl_ready = !srst && (thread_busy != '1);
    assign accept   = sl_valid && sl_ready;

    // First free thread at or after rr_ptr, wrapping around the pool.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        sel_onehot = '0;
        sel_idx    = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < c_NUM_THREADS; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (sum >= PTR_NUM) begin
                sum = sum - PTR_NUM;
            end
            idx = sum[PTR_W-1:0];
            if (sel_onehot == '0 && !thread_busy[idx]) begin
                sel_onehot[idx] = 1'b1;
                sel_idx         = idx;
            end
        end
    end

    // A done pulse on the expiry cycle takes precedence over the timeout.
    always_comb begin
        timeout_hit  = '0;
        release_mask = '0;
        for (int t = 0; t < c_NUM_THREADS; t++) begin
            timeout_hit[t]  = thread_busy[t] && !thread_done[t]
                              && (watchdog[t] == WD_LAST);
            release_mask[t] = thread_busy[t]
                              && (thread_done[t] || watchdog[t] == WD_LAST);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            dispatch_valid  <= 1'b0;
            dispatch_thread <= '0;
            dispatch_id     <= '0;
            thread_busy     <= '0;
            timeout_pulse   <= '0;
            dispatch_count  <= '0;
            timeout_count   <= '0;
            rr_ptr          <= '0;
            for (int t = 0; t < c_NUM_THREADS; t++) begin
                watchdog[t] <= '0;
            end
        end else if (srst) begin
            dispatch_valid  <= 1'b0;
            dispatch_thread <= '0;
            dispatch_id     <= '0;
            thread_busy     <= '0;
            timeout_pulse   <= '0;
            dispatch_count  <= '0;
            timeout_count   <= '0;
            rr_ptr          <= '0;
            for (int t = 0; t < c_NUM_THREADS; t++) begin
                watchdog[t] <= '0;
            end
        end else begin
            dispatch_valid <= accept;
            timeout_pulse  <= timeout_hit;
            thread_busy    <= (thread_busy & ~release_mask)
                              | (accept ? sel_onehot : '0);
            if (accept) begin
                dispatch_thread <= sel_onehot;
                dispatch_id     <= sl_id;
                rr_ptr          <= (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
                if (dispatch_count != '1) begin
                    dispatch_count <= dispatch_count + 1'b1;
                end
            end
            // One increment per cycle regardless of how many threads expire.
            if (|timeout_hit && timeout_count != '1) begin
                timeout_count <= timeout_count + 1'b1;
            end
            for (int t = 0; t < c_NUM_THREADS; t++) begin
                if (accept && sel_onehot[t]) begin
                    watchdog[t] <= '0;
                end else if (thread_busy[t] && !release_mask[t]) begin
                    watchdog[t] <= watchdog[t] + 1'b1;
                end else begin
                    watchdog[t] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mtc_thread_scheduler.sv
// Directed bench for mtc_thread_scheduler: round-robin, reuse, resets, watchdog, saturation.
module tb_mtc_thread_scheduler;

    logic       clock;
    logic       rst;
    logic       srst;
    logic       sl_valid;
    logic [3:0] sl_id;
    logic       sl_ready;
    logic [2:0] thread_done;
    logic       dispatch_valid;
    logic [2:0] dispatch_thread;
    logic [3:0] dispatch_id;
    logic [2:0] thread_busy;
    logic [2:0] timeout_pulse;
    logic [15:0] dispatch_count;
    logic [15:0] timeout_count;

    logic       s_sl_ready;
    logic       s_dispatch_valid;
    logic [2:0] s_dispatch_thread;
    logic [3:0] s_dispatch_id;
    logic [2:0] s_thread_busy;
    logic [2:0] s_timeout_pulse;
    logic [1:0] s_dispatch_count;
    logic [1:0] s_timeout_count;

    int checks = 0;
    int errors = 0;

    mtc_thread_scheduler dut (
        .clock(clock), .rst(rst), .srst(srst),
        .sl_valid(sl_valid), .sl_id(sl_id), .sl_ready(sl_ready),
        .thread_done(thread_done),
        .dispatch_valid(dispatch_valid), .dispatch_thread(dispatch_thread),
        .dispatch_id(dispatch_id), .thread_busy(thread_busy),
        .timeout_pulse(timeout_pulse), .dispatch_count(dispatch_count),
        .timeout_count(timeout_count)
    );

    mtc_thread_scheduler #(.CNT_WIDTH(2)) u_small (
        .clock(clock), .rst(rst), .srst(srst),
        .sl_valid(sl_valid), .sl_id(sl_id), .sl_ready(s_sl_ready),
        .thread_done(thread_done),
        .dispatch_valid(s_dispatch_valid), .dispatch_thread(s_dispatch_thread),
        .dispatch_id(s_dispatch_id), .thread_busy(s_thread_busy),
        .timeout_pulse(s_timeout_pulse), .dispatch_count(s_dispatch_count),
        .timeout_count(s_timeout_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        sl_valid    = 1'b0;
        sl_id       = '0;
        thread_done = '0;
        srst        = 1'b0;
        step();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; srst = 1'b0; sl_valid = 1'b0; sl_id = '0; thread_done = '0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({dispatch_valid, dispatch_thread, dispatch_id, thread_busy, timeout_pulse} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0",
                     {dispatch_valid, dispatch_thread, dispatch_id, thread_busy, timeout_pulse});
        end
        checks++;
        if (dispatch_count !== 16'd0 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", dispatch_count, timeout_count);
        end
        checks++;
        if (sl_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", sl_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_thr [3];
        logic [2:0] exp_busy [3];
        exp_thr  = '{3'b001, 3'b010, 3'b100};
        exp_busy = '{3'b001, 3'b011, 3'b111};
        sl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sl_id = 4'(i + 1);
            step();
            checks++;
            if (dispatch_valid !== 1'b1 || dispatch_thread !== exp_thr[i]
                || dispatch_id !== 4'(i + 1)) begin
                errors++;
                $display("FAIL rr_dispatch%0d: got v=%b thr=%b id=%0d want v=1 thr=%b id=%0d",
                         i, dispatch_valid, dispatch_thread, dispatch_id, exp_thr[i], i + 1);
            end
            checks++;
            if (thread_busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL rr_busy%0d: got %b want %b", i, thread_busy, exp_busy[i]);
            end
        end
        checks++;
        if (sl_ready !== 1'b0 || dispatch_count !== 16'd3) begin
            errors++;
            $display("FAIL rr_full: got ready=%b count=%0d want ready=0 count=3",
                     sl_ready, dispatch_count);
        end
        sl_valid = 1'b0;
        step();
        checks++;
        if (dispatch_valid !== 1'b0 || dispatch_thread !== 3'b100 || dispatch_id !== 4'd3) begin
            errors++;
            $display("FAIL rr_hold: got v=%b thr=%b id=%0d want v=0 thr=100 id=3",
                     dispatch_valid, dispatch_thread, dispatch_id);
        end
    endtask

    task automatic test_done_reuse();
        thread_done = 3'b010;
        sl_valid    = 1'b1;
        sl_id       = 4'd7;
        #1;
        checks++;
        if (sl_ready !== 1'b0) begin
            errors++;
            $display("FAIL reuse_ready_before: got %b want 0", sl_ready);
        end
        step();
        thread_done = '0;
        #1;
        checks++;
        if (sl_ready !== 1'b1 || thread_busy !== 3'b101 || dispatch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reuse_freed: got ready=%b busy=%b v=%b want 1 101 0",
                     sl_ready, thread_busy, dispatch_valid);
        end
        step();
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_thread !== 3'b010 || dispatch_id !== 4'd7) begin
            errors++;
            $display("FAIL reuse_dispatch: got v=%b thr=%b id=%0d want 1 010 7",
                     dispatch_valid, dispatch_thread, dispatch_id);
        end
        sl_valid    = 1'b0;
        thread_done = 3'b101;
        step();
        thread_done = '0;
        sl_valid    = 1'b1;
        sl_id       = 4'd9;
        step();
        sl_valid = 1'b0;
        checks++;
        if (dispatch_thread !== 3'b100 || thread_busy !== 3'b110 || dispatch_count !== 16'd5) begin
            errors++;
            $display("FAIL reuse_rrptr: got thr=%b busy=%b count=%0d want 100 110 5",
                     dispatch_thread, thread_busy, dispatch_count);
        end
    endtask

    task automatic test_srst();
        do_reset();
        sl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sl_id = 4'(i + 10);
            step();
        end
        srst = 1'b1;
        #1;
        checks++;
        if (sl_ready !== 1'b0) begin
            errors++;
            $display("FAIL srst_ready: got %b want 0", sl_ready);
        end
        step();
        srst  = 1'b0;
        sl_id = 4'd5;
        checks++;
        if ({dispatch_valid, dispatch_thread, dispatch_id, thread_busy, timeout_pulse} !== 14'd0
            || dispatch_count !== 16'd0) begin
            errors++;
            $display("FAIL srst_clear: got busy=%b thr=%b count=%0d want 0",
                     thread_busy, dispatch_thread, dispatch_count);
        end
        step();
        sl_valid = 1'b0;
        checks++;
        if (dispatch_thread !== 3'b001 || dispatch_id !== 4'd5 || dispatch_count !== 16'd1) begin
            errors++;
            $display("FAIL srst_first: got thr=%b id=%0d count=%0d want 001 5 1",
                     dispatch_thread, dispatch_id, dispatch_count);
        end
    endtask

    task automatic test_async_rst();
        sl_valid = 1'b1;
        sl_id    = 4'd6;
        step();
        sl_id = 4'd7;
        step();
        sl_valid = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if (thread_busy !== 3'b000 || dispatch_thread !== 3'b000 || dispatch_count !== 16'd0) begin
            errors++;
            $display("FAIL arst_clear: got busy=%b thr=%b count=%0d want 0 0 0",
                     thread_busy, dispatch_thread, dispatch_count);
        end
        rst = 1'b0;
        step();
        sl_valid = 1'b1;
        sl_id    = 4'd8;
        step();
        sl_valid = 1'b0;
        checks++;
        if (dispatch_thread !== 3'b001 || thread_busy !== 3'b001) begin
            errors++;
            $display("FAIL arst_first: got thr=%b busy=%b want 001 001",
                     dispatch_thread, thread_busy);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        sl_valid = 1'b1;
        sl_id    = 4'd2;
        step();
        sl_valid = 1'b0;
        bad = 0;
        for (int i = 1; i < 64; i++) begin
            step();
            if (timeout_pulse !== 3'b000 || thread_busy !== 3'b001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: got %0d bad cycles want 0", bad);
        end
        step();
        checks++;
        if (timeout_pulse !== 3'b001 || thread_busy !== 3'b000 || timeout_count !== 16'd1) begin
            errors++;
            $display("FAIL timeout_fire: got pulse=%b busy=%b count=%0d want 001 000 1",
                     timeout_pulse, thread_busy, timeout_count);
        end
        step();
        checks++;
        if (timeout_pulse !== 3'b000 || timeout_count !== 16'd1) begin
            errors++;
            $display("FAIL timeout_after: got pulse=%b count=%0d want 000 1",
                     timeout_pulse, timeout_count);
        end
    endtask

    task automatic test_done_beats_timeout();
        do_reset();
        sl_valid = 1'b1;
        sl_id    = 4'd4;
        step();
        sl_valid = 1'b0;
        for (int i = 1; i < 64; i++) step();
        thread_done = 3'b001;
        step();
        thread_done = '0;
        checks++;
        if (thread_busy !== 3'b000 || timeout_pulse !== 3'b000 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL done_wins: got busy=%b pulse=%b count=%0d want 000 000 0",
                     thread_busy, timeout_pulse, timeout_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sl_valid = 1'b1;
        sl_id    = 4'd1;
        step();
        sl_id = 4'd2;
        step();
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_thread !== 3'b010) begin
            errors++;
            $display("FAIL b2b_second: got v=%b thr=%b want 1 010", dispatch_valid, dispatch_thread);
        end
        sl_id       = 4'd3;
        thread_done = 3'b001;
        step();
        sl_valid    = 1'b0;
        thread_done = '0;
        checks++;
        if (dispatch_thread !== 3'b100 || thread_busy !== 3'b110 || dispatch_count !== 16'd3) begin
            errors++;
            $display("FAIL b2b_accept_release: got thr=%b busy=%b count=%0d want 100 110 3",
                     dispatch_thread, thread_busy, dispatch_count);
        end
    endtask

    task automatic test_spurious_saturation();
        logic [2:0] exp_thr [4];
        exp_thr = '{3'b010, 3'b100, 3'b001, 3'b010};
        do_reset();
        sl_valid = 1'b1;
        sl_id    = 4'd1;
        step();
        sl_valid    = 1'b0;
        thread_done = 3'b100;
        step();
        thread_done = '0;
        checks++;
        if (thread_busy !== 3'b001 || timeout_pulse !== 3'b000) begin
            errors++;
            $display("FAIL spurious_done: got busy=%b pulse=%b want 001 000",
                     thread_busy, timeout_pulse);
        end
        checks++;
        if (s_dispatch_count !== 2'd1) begin
            errors++;
            $display("FAIL sat_first: got %0d want 1", s_dispatch_count);
        end
        thread_done = 3'b001;
        step();
        thread_done = '0;
        for (int i = 0; i < 4; i++) begin
            sl_valid = 1'b1;
            sl_id    = 4'(i + 2);
            step();
            sl_valid = 1'b0;
            checks++;
            if (dispatch_thread !== exp_thr[i]) begin
                errors++;
                $display("FAIL sat_thread%0d: got %b want %b", i, dispatch_thread, exp_thr[i]);
            end
            thread_done = 3'b111;
            step();
            thread_done = '0;
        end
        checks++;
        if (dispatch_count !== 16'd5 || thread_busy !== 3'b000) begin
            errors++;
            $display("FAIL sat_wide: got count=%0d busy=%b want 5 000", dispatch_count, thread_busy);
        end
        checks++;
        if (s_dispatch_count !== 2'd3) begin
            errors++;
            $display("FAIL sat_narrow: got %0d want 3", s_dispatch_count);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_done_reuse();
        test_srst();
        test_async_rst();
        test_timeout();
        test_done_beats_timeout();
        test_back_to_back();
        test_spurious_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtc_thread_scheduler.md
Name: mtc_thread_scheduler

Overview:
- Dispatch controller in front of the pT-calc thread pool that feeds the MTC builder.
- Accepts one sector-logic (SL) candidate per cycle over a valid/ready handshake and assigns it to a free pT-calc thread, round-robin.
- Tracks per-thread busy state. Releases a thread on its done pulse or on a watchdog timeout.
- Provides dispatch and timeout statistics for monitoring.

Parameters:
- c_NUM_THREADS, 3: number of pT-calc threads; legal range 2..8.
- SL_ID_WIDTH, 4: width of the candidate tag passed through to the thread.
- TIMEOUT, 64: cycles a thread may stay busy before forced release; must be ≥ 2.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clock, input, 1: single clock domain.
- rst, input, 1: asynchronous, active-high reset.
- srst, input, 1: synchronous, active-high soft reset.
- sl_valid, input, 1: candidate present.
- sl_id, input, SL_ID_WIDTH: candidate tag.
- sl_ready, output, 1: scheduler can accept this cycle.
- thread_done, input, c_NUM_THREADS: per-thread one-cycle completion pulse.
- dispatch_valid, output, 1: dispatch strobe to the thread pool.
- dispatch_thread, output, c_NUM_THREADS: one-hot target thread.
- dispatch_id, output, SL_ID_WIDTH: tag forwarded with the dispatch.
- thread_busy, output, c_NUM_THREADS: registered busy mask.
- timeout_pulse, output, c_NUM_THREADS: one-cycle pulse on forced release.
- dispatch_count, output, CNT_WIDTH: accepted candidates, saturating.
- timeout_count, output, CNT_WIDTH: forced releases, saturating.

Behaviour:
- Reset (rst asynchronous, or srst at a rising edge) sets all of the following to 0:
  - registered outputs: dispatch_valid, dispatch_thread, dispatch_id, thread_busy, timeout_pulse, dispatch_count, timeout_count
  - internal state: rr_ptr, per-thread watchdog counters.
- sl_ready is combinational: sl_ready = !srst && (thread_busy != all-ones). It has no dependency on sl_valid.
- Accept occurs when sl_valid && sl_ready at a rising edge.
- Thread selection: first thread t with thread_busy[t]==0, searched from rr_ptr upward, wrapping modulo c_NUM_THREADS.
- Dispatch latency is 1 cycle. At the accept edge:
  - dispatch_valid <= 1, dispatch_thread <= onehot(t), dispatch_id <= sl_id
  - thread_busy[t] <= 1, watchdog[t] <= 0
  - rr_ptr <= (t+1) mod c_NUM_THREADS
  - dispatch_count increments, saturating.
- With no accept, dispatch_valid <= 0. dispatch_thread and dispatch_id hold their previous values.
- Done handling:
  - thread_done[t] while busy clears busy[t] at that edge. The freed thread becomes eligible the following cycle, because sl_ready uses the registered mask.
  - thread_done on an idle thread is ignored.
- Watchdog:
  - Each busy thread's counter increments every cycle.
  - When the counter == TIMEOUT-1 and thread_done[t]==0, at that edge: busy[t] <= 0, timeout_pulse[t] <= 1 for one cycle, timeout_count increments (saturating).
  - A thread therefore occupies at most TIMEOUT cycles.
- Simultaneous done and timeout on the same thread: done wins; no timeout_pulse, no count.
- Accept and release in the same cycle can only target different threads, since the chosen thread is already free. Both updates apply at that edge.
- Multiple timeouts in one cycle: each thread pulses; timeout_count increments by 1 per cycle, not by popcount. This is a documented limitation.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Reset mid-dispatch: all in-flight threads are forgotten. The first dispatch after reset goes to thread 0.

Test Plan:
- Reset, then present ids 1,2,3 on consecutive cycles with no done -> dispatch_thread = 001, 010, 100 on cycles 1..3; thread_busy = 111; sl_ready = 0 from the cycle after the third accept; dispatch_count = 3.
- All threads busy; pulse thread_done[1]; hold sl_valid with id 7 -> sl_ready rises the next cycle; accept dispatches to 010 with dispatch_id = 7; rr_ptr = 2.
- Dispatch to thread 0, no done for 64 cycles (TIMEOUT = 64) -> timeout_pulse = 001 exactly 64 cycles after the accept edge; thread_busy[0] = 0; timeout_count = 1.
- Pulse thread_done[0] on the same cycle its watchdog reaches 63 -> busy clears; no timeout_pulse; timeout_count unchanged.
- Three threads busy, assert srst for one cycle mid-stream -> all outputs 0; sl_ready = 0 during srst; next accept goes to thread 0. Repeat with asynchronous rst asserted between edges -> outputs clear immediately.
- Spurious thread_done[2] while idle, plus CNT_WIDTH = 2 with 5 accepts -> busy mask unaffected; dispatch_count saturates at 3.
